hbridge_motor_driver: RTL and testbench
=======================================

Name: hbridge_motor_driver

Overview:
- Consumes per-motor direction bits (fwd/rev pairs for motors A and B) from the microbot navigation FSM.
- Produces PWM-modulated H-bridge gate inputs (IN1/IN2 per motor).
- Enforces dead-time on every direction reversal, so both legs of one bridge are never driven high together.
- Sits between the navigation controller outputs and the motor-driver pins.

Parameters:
- PWM_BITS, 8, width of the PWM counter and duty input; PWM period = 2^PWM_BITS clocks.
- DEAD_CYCLES, 4, clocks both bridge inputs are held low on a FWD<->REV reversal; legal range 1..255.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; synchronous, active-low.
- ena  in  1  block enable; low forces coast.
- cmd_a_fwd  in  1  motor A forward request.
- cmd_a_rev  in  1  motor A reverse request.
- cmd_b_fwd  in  1  motor B forward request.
- cmd_b_rev  in  1  motor B reverse request.
- duty  in  PWM_BITS  on-time per period; shared by both motors.
- a_in1  out  1  motor A bridge leg 1.
- a_in2  out  1  motor A bridge leg 2.
- b_in1  out  1  motor B bridge leg 1.
- b_in2  out  1  motor B bridge leg 2.
- fault  out  2  [0]=A, [1]=B; high while that motor's command is illegal (fwd=rev=1).
- pwm_wrap  out  1  one-cycle pulse when the PWM counter wraps to 0.

Behaviour:
- Reset (rst_n=0 at a clk edge): pwm_cnt=0, duty_q=0, both channels COAST, all in1/in2=0, fault=0, pwm_wrap=0.
- PWM counter: free-running 0..2^PWM_BITS-1, wraps to 0.
  - duty_q loads duty only on the edge where the counter wraps, so there are no mid-period glitches.
  - pwm_on = (pwm_cnt < duty_q). duty=0 gives always off; duty=255 gives 255/256 on.
  - pwm_wrap is registered and high in the cycle pwm_cnt==0.
- ena=0: counter held at 0, both channels forced to COAST, outputs 0, fault still reported. On ena rising, behaviour is as if out of reset, except that duty_q is retained.
- Command decode per channel:
  - 10 = FWD, 01 = REV, 00 = COAST.
  - 11 = illegal: treated as COAST; fault bit set (registered, one-cycle latency) and cleared the cycle after the command becomes legal.
- Channel FSM states: COAST, FWD, REV, DEAD.
  - COAST -> FWD/REV: directly on a legal command.
  - FWD/REV -> COAST: immediately on a 00 or 11 command.
  - FWD -> REV or REV -> FWD: enter DEAD, load dead counter with DEAD_CYCLES-1, count down.
  - DEAD exit (counter=0): go to the state the current command decodes to. A command that changes during DEAD is honoured only at exit; DEAD is never shortened.
  - Same-direction command while in FWD/REV: stay.
- Outputs are registered from state and pwm_on:
  - FWD: in1=pwm_on, in2=0.
  - REV: in1=0, in2=pwm_on.
  - COAST/DEAD: 0,0.
- Latency: command change at edge N -> state update at edge N+1 -> pins update at edge N+2.
- Invariant: in1 & in2 == 0 on every cycle, for both channels.
- Reversal timing: the last driven cycle of the old direction and the first driven cycle of the new direction are separated by >= DEAD_CYCLES low cycles.
- Reset asserted mid-DEAD or mid-period: the next edge gives the full reset values.

Optional Feature:
- Macro HBRIDGE_SOFT_START_EN.
- When defined: each channel keeps an effective duty register.
  - Reset to 0 on COAST or DEAD entry.
  - On each pwm_wrap while in FWD/REV, it increments by 1 toward duty_q; it never overshoots.
  - If duty_q drops below it, it snaps to duty_q.
  - The pwm_on compare uses the effective duty.
- When undefined: duty_q is used directly and there is no ramp logic.

Decomposition:
- Package microbot_motor_pkg:
  - Channel state encoding: COAST=2'b00, FWD=2'b01, REV=2'b10, DEAD=2'b11.
  - Command decode constants.
  - Default PWM_BITS/DEAD_CYCLES values.
- Sub-module hbridge_channel, instantiated twice:
  - Handles command decode, FSM, dead counter, fault, output registers and the optional ramp.
  - Takes pwm_cnt, duty_q, pwm_wrap and ena from the top.
- The top owns the PWM counter, duty latch and port mapping.

Test Plan:
- Reset/idle: rst_n=0 for 3 cycles, then all commands 0, duty=128 -> all in1/in2=0, fault=00 for 600 cycles.
- Forward PWM: cmd_a_fwd=1, duty=64 -> a_in1 high exactly 64 of every 256 cycles after the first wrap; a_in2=0; pin edge 2 cycles after the command.
- Reversal: A in FWD, then switch to cmd_a_rev at cycle T -> a_in1=a_in2=0 for >=4 cycles, then a_in2 pulses with PWM; checker finds in1&in2 never true.
- Illegal command: cmd_b_fwd=cmd_b_rev=1 for 10 cycles -> fault[1]=1 one cycle later, b_in1=b_in2=0; restore 10 -> fault[1] clears and FWD resumes with no DEAD.
- Duty change mid-period: duty 200 -> 20 at pwm_cnt=50 -> the current period completes with 200, the next period uses 20.
- ena/reset mid-DEAD: drop ena (or rst_n) during DEAD -> outputs 0 at the next edge; on return with cmd REV -> REV driven with no residual dead count. With HBRIDGE_SOFT_START_EN: duty=5 ramps 1,2,3,4,5 over successive periods.

Source files
------------

// File: rtl/microbot_motor_pkg.sv
// Shared types and defaults for the microbot H-bridge driver.
// Optional soft-start ramp is enabled with HBRIDGE_SOFT_START_EN.
package microbot_motor_pkg;

  localparam int PWM_BITS_DEF    = 8;
  localparam int DEAD_CYCLES_DEF = 4;
  localparam int NUM_CH          = 2;
  localparam int DEAD_W          = 8;

  typedef enum logic [1:0] {
    ST_COAST = 2'b00,
    ST_FWD   = 2'b01,
    ST_REV   = 2'b10,
    ST_DEAD  = 2'b11
  } ch_state_e;

  // Command pair is {fwd, rev}.
  typedef enum logic [1:0] {
    CMD_COAST = 2'b00,
    CMD_REV   = 2'b01,
    CMD_FWD   = 2'b10,
    CMD_ILL   = 2'b11
  } ch_cmd_e;

  typedef struct packed {
    logic fwd;
    logic rev;
  } ch_cmd_t;

  typedef struct packed {
    logic in1;
    logic in2;
  } ch_out_t;

  // Illegal commands fall through to COAST.
  function automatic ch_state_e cmd_target(input ch_cmd_e c);
    case (c)
      CMD_FWD: cmd_target = ST_FWD;
      CMD_REV: cmd_target = ST_REV;
      default: cmd_target = ST_COAST;
    endcase
  endfunction

endpackage

// File: rtl/hbridge_channel.sv
// One H-bridge channel: command decode, dead-time FSM, fault flag, gate registers.
// HBRIDGE_SOFT_START_EN adds a per-channel duty ramp toward the latched duty.
module hbridge_channel
  import microbot_motor_pkg::*;
#(
  parameter int PWM_BITS    = PWM_BITS_DEF,
  parameter int DEAD_CYCLES = DEAD_CYCLES_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  ch_cmd_t             cmd,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  input  logic [PWM_BITS-1:0] duty_q,
  input  logic                pwm_wrap,
  output ch_out_t             out,
  output logic                fault
);

  localparam logic [DEAD_W-1:0] DEAD_LOAD = DEAD_W'(DEAD_CYCLES - 1);

  ch_cmd_e             cmd_e;
  ch_state_e           state_q, state_d;
  logic [DEAD_W-1:0]   dead_q, dead_d;
  ch_out_t             out_q, out_d;
  logic                fault_q, fault_d;
  logic [PWM_BITS-1:0] duty_eff;
  logic                pwm_on;

  assign cmd_e = ch_cmd_e'({cmd.fwd, cmd.rev});

`ifdef HBRIDGE_SOFT_START_EN
  logic [PWM_BITS-1:0] eff_q, eff_d;

  // The compare uses the next value so a wrap step applies from pwm_cnt==0.
  always_comb begin
    eff_d = eff_q;
    if (!ena || !(state_q inside {ST_FWD, ST_REV}))
      eff_d = '0;
    else if (duty_q < eff_q)
      eff_d = duty_q;
    else if (pwm_wrap && (eff_q < duty_q))
      eff_d = eff_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) eff_q <= '0;
    else        eff_q <= eff_d;
  end

  assign duty_eff = eff_d;
`else
  logic unused_wrap;
  assign unused_wrap = pwm_wrap;
  assign duty_eff    = duty_q;
`endif

  assign pwm_on = (pwm_cnt < duty_eff);

  always_comb begin
    state_d = state_q;
    dead_d  = dead_q;
    if (!ena) begin
      state_d = ST_COAST;
      dead_d  = '0;
    end else begin
      case (state_q)
        ST_COAST: state_d = cmd_target(cmd_e);
        ST_FWD: begin
          if (cmd_e == CMD_REV) begin
            state_d = ST_DEAD;
            dead_d  = DEAD_LOAD;
          end else begin
            state_d = cmd_target(cmd_e);
          end
        end
        ST_REV: begin
          if (cmd_e == CMD_FWD) begin
            state_d = ST_DEAD;
            dead_d  = DEAD_LOAD;
          end else begin
            state_d = cmd_target(cmd_e);
          end
        end
        default: begin
          // DEAD runs its full length; the command is only looked at on exit.
          if (dead_q == '0) state_d = cmd_target(cmd_e);
          else              dead_d  = dead_q - 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    out_d.in1 = ena && (state_q == ST_FWD) && pwm_on;
    out_d.in2 = ena && (state_q == ST_REV) && pwm_on;
    fault_d   = (cmd_e == CMD_ILL);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_COAST;
      dead_q  <= '0;
      out_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dead_q  <= dead_d;
      out_q   <= out_d;
      fault_q <= fault_d;
    end
  end

  assign out   = out_q;
  assign fault = fault_q;

endmodule

// File: rtl/hbridge_motor_driver.sv
// Two-channel PWM H-bridge driver with dead-time on reversals.
// Build with HBRIDGE_SOFT_START_EN for the per-channel soft-start ramp.
module hbridge_motor_driver
  import microbot_motor_pkg::*;
#(
  parameter int PWM_BITS    = PWM_BITS_DEF,
  parameter int DEAD_CYCLES = DEAD_CYCLES_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                cmd_a_fwd,
  input  logic                cmd_a_rev,
  input  logic                cmd_b_fwd,
  input  logic                cmd_b_rev,
  input  logic [PWM_BITS-1:0] duty,
  output logic                a_in1,
  output logic                a_in2,
  output logic                b_in1,
  output logic                b_in2,
  output logic [1:0]          fault,
  output logic                pwm_wrap
);

  localparam logic [PWM_BITS-1:0] CNT_MAX = '1;

  logic [PWM_BITS-1:0] cnt_q, cnt_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic                wrap_q, wrap_d;

  ch_cmd_t [NUM_CH-1:0] ch_cmd;
  ch_out_t [NUM_CH-1:0] ch_out;
  logic    [NUM_CH-1:0] ch_fault;

  // Duty is only sampled on the wrap edge so a period never changes mid-way.
  always_comb begin
    wrap_d = ena && (cnt_q == CNT_MAX);
    cnt_d  = ena ? cnt_q + 1'b1 : '0;
    duty_d = wrap_d ? duty : duty_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      duty_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      duty_q <= duty_d;
      wrap_q <= wrap_d;
    end
  end

  assign ch_cmd[0] = {cmd_a_fwd, cmd_a_rev};
  assign ch_cmd[1] = {cmd_b_fwd, cmd_b_rev};

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    hbridge_channel #(
      .PWM_BITS   (PWM_BITS),
      .DEAD_CYCLES(DEAD_CYCLES)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .cmd     (ch_cmd[g]),
      .pwm_cnt (cnt_q),
      .duty_q  (duty_q),
      .pwm_wrap(wrap_q),
      .out     (ch_out[g]),
      .fault   (ch_fault[g])
    );
  end

  assign a_in1    = ch_out[0].in1;
  assign a_in2    = ch_out[0].in2;
  assign b_in1    = ch_out[1].in1;
  assign b_in2    = ch_out[1].in2;
  assign fault    = ch_fault;
  assign pwm_wrap = wrap_q;

endmodule

// File: tb/tb_hbridge_motor_driver.sv
// Directed bench for hbridge_motor_driver: cycle-exact vector table plus PWM sequences.
module tb_hbridge_motor_driver;

  logic       clk = 1'b0;
  logic       rst_n, ena;
  logic       cmd_a_fwd, cmd_a_rev, cmd_b_fwd, cmd_b_rev;
  logic [7:0] duty;
  logic       a_in1, a_in2, b_in1, b_in2, pwm_wrap;
  logic [1:0] fault;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hbridge_motor_driver #(.PWM_BITS(8), .DEAD_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .cmd_a_fwd(cmd_a_fwd), .cmd_a_rev(cmd_a_rev),
    .cmd_b_fwd(cmd_b_fwd), .cmd_b_rev(cmd_b_rev),
    .duty(duty),
    .a_in1(a_in1), .a_in2(a_in2), .b_in1(b_in1), .b_in2(b_in2),
    .fault(fault), .pwm_wrap(pwm_wrap)
  );

  // cmd = {a_fwd, a_rev, b_fwd, b_rev}; pins = {a_in1, a_in2, b_in1, b_in2}
  typedef struct {
    logic       rst_n;
    logic       ena;
    logic [3:0] cmd;
    logic [7:0] duty;
    int         cyc;
    logic [3:0] pins;
    logic [1:0] flt;
    logic       wrap;
    string      name;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic e, input logic [3:0] c, input logic [7:0] d,
                     input int n, input logic [3:0] p, input logic [1:0] f, input logic w,
                     input string nm);
    vec_t v;
    v.rst_n = r; v.ena = e; v.cmd = c; v.duty = d; v.cyc = n;
    v.pins = p; v.flt = f; v.wrap = w; v.name = nm;
    vq.push_back(v);
  endtask

  task automatic set_cmd(input logic [3:0] c);
    {cmd_a_fwd, cmd_a_rev, cmd_b_fwd, cmd_b_rev} = c;
  endtask

  // Every clock also checks that no bridge has both legs high.
  task automatic tick();
    @(posedge clk);
    #1;
    checks++;
    if (((a_in1 & a_in2) | (b_in1 & b_in2)) === 1'b1) begin
      errors++;
      $display("FAIL overlap: a=%b%b b=%b%b, need no bridge with both legs high",
               a_in1, a_in2, b_in1, b_in2);
    end
  endtask

  task automatic check(input string nm, input logic [3:0] p, input logic [1:0] f, input logic w);
    checks++;
    if ({a_in1, a_in2, b_in1, b_in2} !== p || fault !== f || pwm_wrap !== w) begin
      errors++;
      $display("FAIL %s: pins=%b fault=%b wrap=%b, expected pins=%b fault=%b wrap=%b",
               nm, {a_in1, a_in2, b_in1, b_in2}, fault, pwm_wrap, p, f, w);
    end
  endtask

  task automatic check_int(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic wait_wrap(input string nm, input int bound);
    int n = 0;
    tick();
    while (pwm_wrap !== 1'b1 && n < bound) begin
      tick();
      n++;
    end
    checks++;
    if (pwm_wrap !== 1'b1) begin
      errors++;
      $display("FAIL %s: no pwm_wrap within %0d cycles", nm, bound);
    end
  endtask

  task automatic count_a(input int n, output int c1, output int c2);
    c1 = 0;
    c2 = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (a_in1 === 1'b1) c1++;
      if (a_in2 === 1'b1) c2++;
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c1, c2, c1b, c2b, last1, first2;

    rst_n = 1'b0; ena = 1'b0; set_cmd(4'b0000); duty = 8'd0;

    // Cycle-exact walk from reset with duty 255 (on for pwm_cnt 0..254).
    add(0, 1, 4'b1011, 255,   3, 4'b0000, 2'b00, 0, "reset");
    add(1, 1, 4'b0000, 255, 256, 4'b0000, 2'b00, 1, "first_wrap");
    add(1, 1, 4'b1000, 255,   1, 4'b0000, 2'b00, 0, "fwd_lat1");
    add(1, 1, 4'b1000, 255,   1, 4'b1000, 2'b00, 0, "fwd_lat2");
    add(1, 1, 4'b0100, 255,   1, 4'b1000, 2'b00, 0, "rev_last_fwd");
    add(1, 1, 4'b0100, 255,   1, 4'b0000, 2'b00, 0, "dead_1");
    add(1, 1, 4'b0100, 255,   3, 4'b0000, 2'b00, 0, "dead_4");
    add(1, 1, 4'b0100, 255,   1, 4'b0100, 2'b00, 0, "rev_on");
    add(1, 1, 4'b0111, 255,   1, 4'b0100, 2'b10, 0, "b_ill_fault");
    add(1, 1, 4'b0111, 255,   9, 4'b0100, 2'b10, 0, "b_ill_hold");
    add(1, 1, 4'b0110, 255,   1, 4'b0100, 2'b00, 0, "b_fault_clr");
    add(1, 1, 4'b0110, 255,   1, 4'b0110, 2'b00, 0, "b_fwd_nodead");
    add(1, 1, 4'b1010, 255,   1, 4'b0110, 2'b00, 0, "a_rev_to_dead");
    add(1, 1, 4'b1010, 255,   1, 4'b0010, 2'b00, 0, "a_dead");
    add(1, 0, 4'b0110, 255,   1, 4'b0000, 2'b00, 0, "ena_off_mid_dead");
    add(1, 1, 4'b0110, 255,   1, 4'b0000, 2'b00, 0, "ena_back_lat1");
    add(1, 1, 4'b0110, 255,   1, 4'b0110, 2'b00, 0, "ena_back_rev");
    add(1, 1, 4'b1010, 255,   1, 4'b0110, 2'b00, 0, "a_dead_again");
    add(0, 1, 4'b1010, 255,   1, 4'b0000, 2'b00, 0, "rst_mid_dead");
    add(1, 1, 4'b1010, 255,   1, 4'b0000, 2'b00, 0, "rst_back_lat1");
    add(1, 1, 4'b1010, 255, 255, 4'b0000, 2'b00, 1, "duty_cleared_wrap");
    add(1, 1, 4'b1010, 255,   1, 4'b1010, 2'b00, 0, "fwd_after_rst");

    foreach (vq[i]) begin
      rst_n = vq[i].rst_n;
      ena   = vq[i].ena;
      set_cmd(vq[i].cmd);
      duty  = vq[i].duty;
      repeat (vq[i].cyc) tick();
      check(vq[i].name, vq[i].pins, vq[i].flt, vq[i].wrap);
    end

    // Idle after reset: nothing driven, no fault.
    rst_n = 1'b0; ena = 1'b1; set_cmd(4'b0000); duty = 8'd128;
    repeat (3) tick();
    check("idle_reset", 4'b0000, 2'b00, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 600; i++) begin
      tick();
      checks++;
      if ({a_in1, a_in2, b_in1, b_in2} !== 4'b0000 || fault !== 2'b00) begin
        errors++;
        $display("FAIL idle cycle %0d: pins=%b fault=%b, expected 0000/00",
                 i, {a_in1, a_in2, b_in1, b_in2}, fault);
      end
    end

    // Forward at duty 64: 64 high cycles per 256-cycle period.
    set_cmd(4'b1000); duty = 8'd64;
    wait_wrap("fwd64_wrap", 300);
    count_a(256, c1, c2);
    check_int("fwd64_in1_p1", c1, 64);
    check_int("fwd64_in2_p1", c2, 0);
    count_a(256, c1, c2);
    check_int("fwd64_in1_p2", c1, 64);

    // Duty 200 -> 20 mid-period: current period keeps 200, next one gets 20.
    duty = 8'd200;
    wait_wrap("duty200_wrap", 300);
    count_a(49, c1, c2);
    duty = 8'd20;
    count_a(207, c1b, c2b);
    check_int("duty_midchange_old", c1 + c1b, 200);
    check("duty_wrap_again", 4'b0000, 2'b00, 1'b1);
    count_a(256, c1, c2);
    check_int("duty_midchange_new", c1, 20);

    // FWD -> REV under PWM: at least 4 low cycles between the two directions.
    last1 = -1;
    first2 = -1;
    set_cmd(4'b0100);
    for (int t = 0; t < 600 && first2 < 0; t++) begin
      tick();
      if (a_in1 === 1'b1) last1 = t;
      if (a_in2 === 1'b1) first2 = t;
    end
    checks++;
    if (first2 < 0 || (first2 - last1 - 1) < 4) begin
      errors++;
      $display("FAIL rev_gap: low gap %0d (first in2 at %0d), expected >= 4",
               first2 - last1 - 1, first2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
